// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM and flag definitions for the registered MY8CPU ALU.
// Imported by the ALU core, its combinational slice and the bus interface users.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_ADC  = 4'd6,
        OP_SBC  = 4'd7,
        OP_CMP  = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_SAR  = 4'd11,
        OP_ROL  = 4'd12,
        OP_ROR  = 4'd13,
        OP_MUL  = 4'd14,
        OP_RSVD = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bit positions inside the {Z,N,C,V} flag vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the sequential ALU: valid/ready in, valid/ready out.
// The ALU uses the slave modport; the register-file/writeback side uses master.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_hi;
    logic [3:0]       flags;
    logic             op_err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, s, s_hi, flags, op_err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, s, s_hi, flags, op_err
    );
endinterface

// File: rtl/alu_seq_comb.sv
// Single-cycle part of the ALU: add/sub family, logic ops, CMP and zero-length
// shifts, plus the Z/N/C/V flags for those results.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic [3:0]       flags,
    output logic             op_err
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] logic_res;
    logic             add_cin;
    logic             sub_cin;
    logic             add_ovf;
    logic             sub_ovf;
    logic             c;
    logic             v;

    // Only ADC/SBC consume the stored carry; the top bit of sum/diff is carry/borrow.
    assign add_cin = (op == OP_ADC) ? cin : 1'b0;
    assign sub_cin = (op == OP_SBC) ? cin : 1'b0;
    assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
    assign diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_cin};
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
        assign logic_res[gi] = (op == OP_AND) ? (a[gi] & b[gi]) :
                               (op == OP_OR)  ? (a[gi] | b[gi]) :
                               (op == OP_XOR) ? (a[gi] ^ b[gi]) : ~a[gi];
    end

    always_comb begin
        s      = '0;
        c      = 1'b0;
        v      = 1'b0;
        op_err = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                s = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = add_ovf;
            end
            OP_SUB, OP_SBC: begin
                s = diff[WIDTH-1:0];
                c = diff[WIDTH];
                v = sub_ovf;
            end
            OP_CMP: begin
                s = a;
                c = diff[WIDTH];
                v = sub_ovf;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                s = logic_res;
            end
            // Reached only for a zero shift amount: operand passes through, carry kept.
            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
                s = a;
                c = cin;
            end
            default: begin
                op_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        flags = '0;
        if (!op_err) begin
            flags[FLAG_Z] = (s == '0);
            flags[FLAG_N] = s[WIDTH-1];
            flags[FLAG_C] = c;
            flags[FLAG_V] = v;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered MY8CPU ALU with valid/ready handshake; shifts run one bit per cycle.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for opcode 14.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_MUL   = MUL;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]       state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [3:0]       op_reg, op_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic             creg_reg, creg_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] s_reg, s_next;
    logic [3:0]       flags_reg, flags_next;
    logic             op_err_reg, op_err_next;

    logic [WIDTH-1:0] comb_s;
    logic [3:0]       comb_flags;
    logic             comb_err;
    logic [WIDTH-1:0] step_val;
    logic             step_c;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             take;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] s_hi_reg, s_hi_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    // sh_reg holds the multiplier and collects the low product bits as it shifts out.
    assign mul_sum = {1'b0, hi_reg} + (sh_reg[0] ? {1'b0, mcand_reg} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], sh_reg[WIDTH-1:1]};
    assign bus.s_hi = s_hi_reg;
`else
    assign bus.s_hi = '0;
`endif

    alu_seq_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
        .cin    (creg_reg),
        .s      (comb_s),
        .flags  (comb_flags),
        .op_err (comb_err)
    );

    // DONE with a same-cycle take behaves like IDLE, giving one op per clock.
    assign bus.in_ready  = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) &&
                           (!out_valid_reg || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign take          = out_valid_reg && bus.out_ready;
    assign shamt         = bus.b[SHW-1:0];
    assign bus.out_valid = out_valid_reg;
    assign bus.s         = s_reg;
    assign bus.flags     = flags_reg;
    assign bus.op_err    = op_err_reg;

    // One-bit step of the shift/rotate in flight; step_c is the bit leaving.
    always_comb begin
        step_c   = sh_reg[0];
        step_val = sh_reg >> 1;
        case (op_reg)
            OP_SHL: begin
                step_c   = sh_reg[WIDTH-1];
                step_val = sh_reg << 1;
            end
            OP_SAR: step_val = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
            OP_ROL: begin
                step_c   = sh_reg[WIDTH-1];
                step_val = {sh_reg[WIDTH-2:0], sh_reg[WIDTH-1]};
            end
            OP_ROR: step_val = {sh_reg[0], sh_reg[WIDTH-1:1]};
            default: ;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        op_next        = op_reg;
        sh_next        = sh_reg;
        creg_next      = creg_reg;
        out_valid_next = out_valid_reg;
        s_next         = s_reg;
        flags_next     = flags_reg;
        op_err_next    = op_err_reg;
`ifdef ALU_SEQ_MUL_EN
        s_hi_next      = s_hi_reg;
        hi_next        = hi_reg;
        mcand_next     = mcand_reg;
`endif

        if (take) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            ST_DONE: begin
                if (take) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sh_next  = step_val;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next            = ST_DONE;
                    out_valid_next        = 1'b1;
                    s_next                = step_val;
                    op_err_next           = 1'b0;
                    creg_next             = step_c;
                    flags_next            = '0;
                    flags_next[FLAG_Z]    = (step_val == '0);
                    flags_next[FLAG_N]    = step_val[WIDTH-1];
                    flags_next[FLAG_C]    = step_c;
`ifdef ALU_SEQ_MUL_EN
                    s_hi_next             = '0;
`endif
                end
            end
            ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                hi_next  = mul_hi;
                sh_next  = mul_lo;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next            = ST_DONE;
                    out_valid_next        = 1'b1;
                    s_next                = mul_lo;
                    s_hi_next             = mul_hi;
                    op_err_next           = 1'b0;
                    creg_next             = (mul_hi != '0);
                    flags_next            = '0;
                    flags_next[FLAG_Z]    = (mul_lo == '0);
                    flags_next[FLAG_N]    = mul_lo[WIDTH-1];
                    flags_next[FLAG_C]    = (mul_hi != '0);
                end
`endif
            end
            default: ;
        endcase

        if (accept) begin
            if (is_shift_op(bus.op) && (shamt != '0)) begin
                state_next = ST_SHIFT;
                sh_next    = bus.a;
                cnt_next   = CW'(shamt);
                op_next    = bus.op;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (bus.op == OP_MUL) begin
                state_next = ST_MUL;
                sh_next    = bus.b;
                hi_next    = '0;
                mcand_next = bus.a;
                cnt_next   = CW'(WIDTH);
            end
`endif
            else begin
                state_next     = ST_DONE;
                out_valid_next = 1'b1;
                s_next         = comb_s;
                flags_next     = comb_flags;
                op_err_next    = comb_err;
`ifdef ALU_SEQ_MUL_EN
                s_hi_next      = '0;
`endif
                // Illegal opcodes must not disturb the carry chain.
                if (!comb_err) begin
                    creg_next = comb_flags[FLAG_C];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            op_reg        <= '0;
            sh_reg        <= '0;
            creg_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            s_reg         <= '0;
            flags_reg     <= '0;
            op_err_reg    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            s_hi_reg      <= '0;
            hi_reg        <= '0;
            mcand_reg     <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_reg        <= op_next;
            sh_reg        <= sh_next;
            creg_reg      <= creg_next;
            out_valid_reg <= out_valid_next;
            s_reg         <= s_next;
            flags_reg     <= flags_next;
            op_err_reg    <= op_err_next;
`ifdef ALU_SEQ_MUL_EN
            s_hi_reg      <= s_hi_next;
            hi_reg        <= hi_next;
            mcand_reg     <= mcand_next;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed vector table, handshake/reset sequences and
// random ops against an arithmetic reference model; follows ALU_SEQ_MUL_EN if defined.
module tb_alu_seq;
    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] s;
        logic [7:0] s_hi;
        logic [3:0] flags;
        logic       err;
        int         lat;
        int         cout;
    } res_t;

    typedef struct {
        int op; int a; int b;
        int s; int s_hi; int flags; int err; int lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_creg = 0;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: summary line not reached");
        $fatal(1, "simulation time limit");
    end

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic int sx(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic res_t mk(input int s, input int hi, input int fl, input int err, input int lat);
        res_t r;
        r.s = 8'(s); r.s_hi = 8'(hi); r.flags = 4'(fl); r.err = err[0]; r.lat = lat; r.cout = 0;
        return r;
    endfunction

    // Reference: integer arithmetic on the opcode definitions, carry-in passed explicitly.
    function automatic res_t model(input int op, input int a, input int b, input int cin);
        res_t m;
        int n, r, sr, hi, c, v, err, s;
        n = b % 8; r = 0; hi = 0; c = 0; v = 0; err = 0; m.lat = 1;
        case (op)
            0, 6: begin
                r  = a + b + ((op == 6) ? cin : 0);
                sr = sx(a) + sx(b) + ((op == 6) ? cin : 0);
                c  = (r > 255) ? 1 : 0;
                v  = (sr > 127 || sr < -128) ? 1 : 0;
            end
            1, 7, 8: begin
                r  = a - b - ((op == 7) ? cin : 0);
                sr = sx(a) - sx(b) - ((op == 7) ? cin : 0);
                c  = (r < 0) ? 1 : 0;
                v  = (sr > 127 || sr < -128) ? 1 : 0;
                if (op == 8) r = a;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~a;
            9:  begin r = a << n;             c = (n == 0) ? cin : ((a >> (8 - n)) & 1); end
            10: begin r = a >> n;             c = (n == 0) ? cin : ((a >> (n - 1)) & 1); end
            11: begin r = sx(a) >>> n;        c = (n == 0) ? cin : ((sx(a) >>> (n - 1)) & 1); end
            12: begin r = ((a << n) | (a >> (8 - n))) & 255; c = (n == 0) ? cin : (r & 1); end
            13: begin r = ((a >> n) | (a << (8 - n))) & 255; c = (n == 0) ? cin : ((r >> 7) & 1); end
`ifdef ALU_SEQ_MUL_EN
            14: begin r = a * b; hi = (r >> 8) & 255; c = (hi != 0) ? 1 : 0; m.lat = 9; end
`endif
            default: err = 1;
        endcase
        if (op >= 9 && op <= 13) m.lat = 1 + n;
        s = r & 255;
        m.s = 8'(s);
        m.s_hi = 8'(hi);
        m.err = err[0];
        m.flags = (err != 0) ? 4'd0 :
                  4'(((s == 0) ? 8 : 0) + ((s > 127) ? 4 : 0) + ((c != 0) ? 2 : 0) + ((v != 0) ? 1 : 0));
        m.cout = (err != 0) ? cin : c;
        return m;
    endfunction

    task automatic run_op(input int op, input int a, input int b, output res_t got);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!bus.in_ready) check("in_ready_wait", 0, 1);
        bus.in_valid = 1'b1; bus.op = 4'(op); bus.a = 8'(a); bus.b = 8'(b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        got.lat = 1;
        while (!bus.out_valid && got.lat < 50) begin
            @(posedge clk); #1; got.lat++;
        end
        got.s = bus.s; got.s_hi = bus.s_hi; got.flags = bus.flags; got.err = bus.op_err; got.cout = 0;
    endtask

    task automatic compare_res(input string tag, input int op, input int a, input int b,
                               input res_t got, input res_t exp);
        $display("%s op=%0d a=%02h b=%02h -> s=%02h s_hi=%02h flags=%04b err=%0d lat=%0d",
                 tag, op, a, b, got.s, got.s_hi, got.flags, got.err, got.lat);
        check({tag, ".s"},     int'(got.s),     int'(exp.s));
        check({tag, ".s_hi"},  int'(got.s_hi),  int'(exp.s_hi));
        check({tag, ".flags"}, int'(got.flags), int'(exp.flags));
        check({tag, ".err"},   int'(got.err),   int'(exp.err));
        check({tag, ".lat"},   got.lat,         exp.lat);
    endtask

    initial begin
        vec_t tbl[19];
        res_t got;
        res_t exp;
        int   op, a, b;

        //          op  a      b      s      hi flags    err lat
        tbl[0]  = '{0,  'hFF, 'h01, 'h00, 0, 'b1010, 0, 1};
        tbl[1]  = '{1,  'h80, 'h01, 'h7F, 0, 'b0001, 0, 1};
        tbl[2]  = '{0,  'hFF, 'h01, 'h00, 0, 'b1010, 0, 1};
        tbl[3]  = '{7,  'h00, 'h00, 'hFF, 0, 'b0110, 0, 1};
        tbl[4]  = '{9,  'h81, 'h03, 'h08, 0, 'b0000, 0, 4};
        tbl[5]  = '{13, 'h01, 'h01, 'h80, 0, 'b0110, 0, 2};
        tbl[6]  = '{15, 'hAA, 'h55, 'h00, 0, 'b0000, 1, 1};
        tbl[7]  = '{6,  'h00, 'h00, 'h01, 0, 'b0000, 0, 1};
        tbl[8]  = '{8,  'h05, 'h07, 'h05, 0, 'b0010, 0, 1};
        tbl[9]  = '{12, 'h55, 'h08, 'h55, 0, 'b0010, 0, 1};
        tbl[10] = '{2,  'hF0, 'h3C, 'h30, 0, 'b0000, 0, 1};
        tbl[11] = '{3,  'h00, 'h00, 'h00, 0, 'b1000, 0, 1};
        tbl[12] = '{4,  'hA5, 'hFF, 'h5A, 0, 'b0000, 0, 1};
        tbl[13] = '{5,  'h0F, 'h00, 'hF0, 0, 'b0100, 0, 1};
        tbl[14] = '{0,  'h7F, 'h01, 'h80, 0, 'b0101, 0, 1};
        tbl[15] = '{11, 'h90, 'h02, 'hE4, 0, 'b0100, 0, 3};
        tbl[16] = '{10, 'hC0, 'h07, 'h01, 0, 'b0010, 0, 8};
        tbl[17] = '{12, 'h80, 'h01, 'h01, 0, 'b0010, 0, 2};
`ifdef ALU_SEQ_MUL_EN
        tbl[18] = '{14, 'h10, 'h20, 'h00, 2, 'b1010, 0, 9};
`else
        tbl[18] = '{14, 'h10, 'h20, 'h00, 0, 'b0000, 1, 1};
`endif

        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = 4'd0; bus.a = 8'h00; bus.b = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready",  int'(bus.in_ready),  1);
        check("reset.out_valid", int'(bus.out_valid), 0);
        check("reset.s",         int'(bus.s),         0);
        check("reset.s_hi",      int'(bus.s_hi),      0);
        check("reset.flags",     int'(bus.flags),     0);
        check("reset.op_err",    int'(bus.op_err),    0);
        rst_n = 1'b1;
        m_creg = 0;

        for (int i = 0; i < 19; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, got);
            compare_res($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, got,
                        mk(tbl[i].s, tbl[i].s_hi, tbl[i].flags, tbl[i].err, tbl[i].lat));
            exp = model(tbl[i].op, tbl[i].a, tbl[i].b, m_creg);
            m_creg = exp.cout;
        end

        // Output held under back-pressure while a new request waits.
        run_op(0, 3, 4, got);
        compare_res("hold_add", 0, 3, 4, got, mk('h07, 0, 'b0000, 0, 1));
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.op = 4'd4; bus.a = 8'hFF; bus.b = 8'h0F;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("hold.s",        int'(bus.s),         'h07);
            check("hold.flags",    int'(bus.flags),     0);
            check("hold.valid",    int'(bus.out_valid), 1);
            check("hold.in_ready", int'(bus.in_ready),  0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("hold.next_s",     int'(bus.s),         'hF0);
        check("hold.next_flags", int'(bus.flags),     'b0100);
        check("hold.next_valid", int'(bus.out_valid), 1);
        @(posedge clk); #1;
        check("hold.drained",    int'(bus.out_valid), 0);
        m_creg = 0;

        // Reset while a 7-bit shift is in its second cycle.
        bus.in_valid = 1'b1; bus.op = 4'd9; bus.a = 8'h01; bus.b = 8'h07;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst.out_valid", int'(bus.out_valid), 0);
        check("rst.s",         int'(bus.s),         0);
        check("rst.flags",     int'(bus.flags),     0);
        check("rst.in_ready",  int'(bus.in_ready),  1);
        repeat (2) @(posedge clk);
        #1;
        check("rst.held_valid", int'(bus.out_valid), 0);
        rst_n = 1'b1;
        m_creg = 0;
        run_op(0, 1, 1, got);
        compare_res("post_rst_add", 0, 1, 1, got, mk('h02, 0, 'b0000, 0, 1));

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 15));
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            exp = model(op, a, b, m_creg);
            run_op(op, a, b, got);
            compare_res($sformatf("rnd%0d", i), op, a, b, got, exp);
            m_creg = exp.cout;
            if ($urandom_range(0, 3) == 0) begin
                bus.out_ready = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1;
                    check("stall.s",        int'(bus.s),         int'(exp.s));
                    check("stall.valid",    int'(bus.out_valid), 1);
                    check("stall.in_ready", int'(bus.in_ready),  0);
                end
                bus.out_ready = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
